// File: rtl/pll_dyn_cfg_ctrl.sv
// HDMI pixel-clock PLL sequencer: power-up, reset, lock qualification, clkout0 gating,
// runtime divider/duty reconfiguration and bounded loss-of-lock recovery.
module pll_dyn_cfg_ctrl #(
  parameter int unsigned PWD_CYC      = 10,
  parameter int unsigned RST_CYC      = 10,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned ODIV_RST     = 100,
  parameter int unsigned DUTY_RST     = 100
) (
  input  logic       clk_tb,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       cfg_req,
  input  logic [9:0] cfg_odiv,
  input  logic [9:0] cfg_duty,
  input  logic       restart,
  output logic       cfg_ack,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       rstodiv,
  output logic       clkout0_gate,
  output logic [9:0] dyn_odiv,
  output logic [9:0] dyn_duty,
  output logic       locked,
  output logic       busy,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CFG_W   = 10;
  localparam int unsigned TCNT_W  = 13;
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    S_PWD, S_RST, S_LOCK, S_RUN, S_GATE, S_LOAD, S_ODRST, S_FAIL
  } state_t;

  state_t               state_q, state_n;
  logic                 lock_m, lock_s;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_n;
  logic [STAB_W-1:0]    stab_q, stab_n;
  logic                 pend_q, pend_n;
  logic                 fail_attempt;
  logic [RETRY_W-1:0]   retry_d;
  logic [CFG_W-1:0]     odiv_d, duty_d;
  logic                 ack_d, pwd_d, prst_d, rstodiv_d, gate_d, locked_d, busy_d, fail_d;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // State, shared timer and registered outputs; reset itself is not counted toward PWD_CYC
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWD;
      tcnt_q       <= TCNT_W'(PWD_CYC);
      stab_q       <= '0;
      pend_q       <= 1'b0;
      cfg_ack      <= 1'b0;
      pll_pwd      <= 1'b1;
      pll_rst      <= 1'b1;
      rstodiv      <= 1'b0;
      clkout0_gate <= 1'b1;
      dyn_odiv     <= CFG_W'(ODIV_RST);
      dyn_duty     <= CFG_W'(DUTY_RST);
      locked       <= 1'b0;
      busy         <= 1'b1;
      fail         <= 1'b0;
      retry_cnt    <= '0;
    end else begin
      state_q      <= state_n;
      tcnt_q       <= tcnt_n;
      stab_q       <= stab_n;
      pend_q       <= pend_n;
      cfg_ack      <= ack_d;
      pll_pwd      <= pwd_d;
      pll_rst      <= prst_d;
      rstodiv      <= rstodiv_d;
      clkout0_gate <= gate_d;
      dyn_odiv     <= odiv_d;
      dyn_duty     <= duty_d;
      locked       <= locked_d;
      busy         <= busy_d;
      fail         <= fail_d;
      retry_cnt    <= retry_d;
    end
  end

  // Next state, timer loads and next-output decode from the state being entered
  always_comb begin
    state_n      = state_q;
    tcnt_n       = tcnt_q;
    stab_n       = stab_q;
    pend_n       = pend_q;
    retry_d      = retry_cnt;
    odiv_d       = dyn_odiv;
    duty_d       = dyn_duty;
    ack_d        = 1'b0;
    fail_attempt = 1'b0;

    unique case (state_q)
      S_PWD: begin
        if (tcnt_q == '0) begin
          state_n = S_RST;
          tcnt_n  = TCNT_W'(RST_CYC - 1);
        end else begin
          tcnt_n = tcnt_q - TCNT_W'(1);
        end
      end
      S_RST, S_ODRST: begin
        if (tcnt_q == '0) begin
          state_n = S_LOCK;
          tcnt_n  = TCNT_W'(LOCK_TIMEOUT - 1);
          stab_n  = '0;
        end else begin
          tcnt_n = tcnt_q - TCNT_W'(1);
        end
      end
      S_LOCK: begin
        // Lock qualification wins over a timeout expiring on the same cycle
        if (lock_s && stab_q == STAB_W'(LOCK_STABLE - 1)) begin
          state_n = S_RUN;
          retry_d = '0;
          ack_d   = pend_q;
          pend_n  = 1'b0;
        end else begin
          stab_n = lock_s ? stab_q + STAB_W'(1) : '0;
          if (tcnt_q == '0) fail_attempt = 1'b1;
          else              tcnt_n = tcnt_q - TCNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          fail_attempt = 1'b1;
        end else if (cfg_req) begin
          state_n = S_GATE;
          tcnt_n  = TCNT_W'(1);
        end
      end
      S_GATE: begin
        if (tcnt_q == '0) state_n = S_LOAD;
        else              tcnt_n  = tcnt_q - TCNT_W'(1);
      end
      S_LOAD: begin
        state_n = S_ODRST;
        tcnt_n  = TCNT_W'(RST_CYC - 1);
        odiv_d  = cfg_odiv;
        duty_d  = cfg_duty;
        pend_n  = 1'b1;
      end
      S_FAIL: begin
        if (restart) begin
          state_n = S_PWD;
          tcnt_n  = TCNT_W'(PWD_CYC - 1);
          retry_d = '0;
        end
      end
    endcase

    // A pending request survives a retry but is abandoned on S_FAIL
    if (fail_attempt) begin
      if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
        state_n = S_FAIL;
        pend_n  = 1'b0;
      end else begin
        state_n = S_PWD;
        tcnt_n  = TCNT_W'(PWD_CYC - 1);
      end
      if (retry_cnt != '1) retry_d = retry_cnt + RETRY_W'(1);
    end

    pwd_d     = (state_n == S_PWD) || (state_n == S_FAIL);
    prst_d    = (state_n == S_RST) || (state_n == S_FAIL);
    rstodiv_d = (state_n == S_ODRST);
    gate_d    = (state_n != S_RUN);
    locked_d  = (state_n == S_RUN);
    busy_d    = (state_n != S_RUN) && (state_n != S_FAIL);
    fail_d    = (state_n == S_FAIL);
  end

endmodule
